// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready word loader driving an LSB-first serial stream, one bit per en strobe.
// Optional embedded assertions are compiled in when PISO_SERIALIZER_FORMAL_EN is defined.
module piso_serializer #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             en,
  output logic             dout,
  output logic             dout_valid,
  output logic             done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             done_n;
  logic             last_bit;

  assign last_bit   = (state == SHIFT) && en && (cnt == LAST);
  assign in_ready   = rstn && ((state == IDLE) || last_bit);
  assign dout       = sr[0];
  assign dout_valid = (state == SHIFT);

  // State, shift register, bit counter and done pulse registers.
  always_ff @(posedge clk) begin
    state <= state_n;
    sr    <= sr_n;
    cnt   <= cnt_n;
    done  <= done_n;
  end

  // Next-state: load on handshake, shift on en, reload or return to IDLE after the last bit.
  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    done_n  = 1'b0;
    if (!rstn) begin
      state_n = IDLE;
      sr_n    = '0;
      cnt_n   = '0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        state_n = SHIFT;
        sr_n    = in_data;
        cnt_n   = '0;
      end
    end else if (en) begin
      if (cnt == LAST) begin
        done_n  = 1'b1;
        cnt_n   = '0;
        sr_n    = in_valid ? in_data : '0;
        state_n = in_valid ? SHIFT : IDLE;
      end else begin
        sr_n  = {1'b0, sr[WIDTH-1:1]};
        cnt_n = cnt + 1'b1;
      end
    end
  end

`ifdef PISO_SERIALIZER_FORMAL_EN
  logic after_reset;

  // Marks the first cycle out of reset so $past-based checks skip stale history.
  always_ff @(posedge clk) begin
    after_reset <= !rstn;
  end

  a_hold: assert property (@(posedge clk) disable iff (!rstn || after_reset)
    (!$past(en) && !$past(in_valid && in_ready)) |-> (sr == $past(sr)));

  a_shift: assert property (@(posedge clk) disable iff (!rstn || after_reset)
    $past((state == SHIFT) && en && (cnt != LAST)) |-> (sr == {1'b0, $past(sr[WIDTH-1:1])}));

  a_cnt: assert property (@(posedge clk) disable iff (!rstn || after_reset)
    cnt <= LAST);

  a_done: assert property (@(posedge clk) disable iff (!rstn || after_reset)
    !($past(done) && done));

  a_valid: assert property (@(posedge clk) disable iff (!rstn || after_reset)
    dout_valid == (state == SHIFT));

  // in_ready must stay low for the whole time reset is held.
  always_comb begin
    if (!rstn) a_rdy_rst: assert (!in_ready);
  end
`endif

endmodule
